// File: rtl/ps2_keycode_source_pkg.sv
// Shared constants for the PS/2 keycode source: HID usages, scan prefixes,
// the frame FSM state type and the PS/2 parity helper.
package keycode_pkg;

  localparam logic [7:0] KEY_NONE     = 8'd0;
  localparam logic [7:0] KEY_A        = 8'd4;
  localparam logic [7:0] KEY_D        = 8'd7;
  localparam logic [7:0] KEY_S        = 8'd22;
  localparam logic [7:0] KEY_W        = 8'd26;
  localparam logic [7:0] KEY_ENTER    = 8'd40;
  localparam logic [7:0] KEY_ESC      = 8'd41;
  localparam logic [7:0] KEY_SPACE    = 8'd44;
  localparam logic [7:0] KEY_RIGHT    = 8'd79;
  localparam logic [7:0] KEY_LEFT     = 8'd80;
  localparam logic [7:0] KEY_DOWN     = 8'd81;
  localparam logic [7:0] KEY_UP       = 8'd82;
  localparam logic [7:0] KEY_KP_ENTER = 8'd88;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  // PS/2 frames carry odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{parity, data};
  endfunction

endpackage

// File: rtl/ps2_keycode_source_if.sv
// Bundles the PS/2 line inputs and the keycode outputs of the keycode source.
interface ps2_keycode_source_if;

  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       key_event;
  logic       frame_err;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output keycode,
    output key_event,
    output frame_err
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  keycode,
    input  key_event,
    input  frame_err
  );

endinterface

// File: rtl/ps2_keycode_source_ps2_to_hid.sv
// Combinational {ext, scan} to HID usage lookup; unmapped codes give 0.
module ps2_to_hid
  import keycode_pkg::*;
(
  input  logic [8:0] code,
  output logic [7:0] hid
);

  // Scan-code set 2 to HID usage translation table
  always_comb begin
    hid = KEY_NONE;
    case (code)
      9'h076:  hid = KEY_ESC;
      9'h05A:  hid = KEY_ENTER;
      9'h029:  hid = KEY_SPACE;
      9'h01C:  hid = KEY_A;
      9'h023:  hid = KEY_D;
      9'h01D:  hid = KEY_W;
      9'h01B:  hid = KEY_S;
      9'h16B:  hid = KEY_LEFT;
      9'h174:  hid = KEY_RIGHT;
      9'h175:  hid = KEY_UP;
      9'h172:  hid = KEY_DOWN;
      9'h15A:  hid = KEY_KP_ENTER;
      default: hid = KEY_NONE;
    endcase
  end

endmodule

// File: rtl/ps2_keycode_source.sv
// PS/2 keyboard receiver: conditions the lines, deframes bytes and decodes
// make/break/extended sequences into the HID keycode of the held key.
module ps2_keycode_source
  import keycode_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  ps2_keycode_source_if.master bus
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       clk_sync_r;
  logic [1:0]       data_sync_r;
  logic             filt_r;
  logic [FLT_W-1:0] flt_cnt_r;
  logic             fall_r;
  logic             data_s;

  frame_state_t     state_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       shift_r;
  logic             parity_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic             byte_valid_r;
  logic             frame_err_r;

  logic [7:0]       keycode_r;
  logic             key_event_r;
  logic             ext_r;
  logic             brk_r;
  logic [7:0]       hid_s;

  assign data_s = data_sync_r[1];

  // Two-flop synchronizers for both asynchronous PS/2 lines
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], bus.ps2_clk};
      data_sync_r <= {data_sync_r[0], bus.ps2_data};
    end
  end

  // Level filter on ps2_clk; fall_r strobes on the accepted high-to-low change
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      filt_r    <= 1'b1;
      flt_cnt_r <= '0;
      fall_r    <= 1'b0;
    end else if (clk_sync_r[1] != filt_r) begin
      if (flt_cnt_r == FLT_LAST) begin
        filt_r    <= clk_sync_r[1];
        flt_cnt_r <= '0;
        fall_r    <= filt_r;
      end else begin
        flt_cnt_r <= flt_cnt_r + FLT_W'(1);
        fall_r    <= 1'b0;
      end
    end else begin
      flt_cnt_r <= '0;
      fall_r    <= 1'b0;
    end
  end

  // Frame FSM: start, eight data bits LSB first, parity, stop, with timeout
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'd0;
      parity_r     <= 1'b0;
      to_cnt_r     <= '0;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      if (fall_r) begin
        to_cnt_r <= '0;
        case (state_r)
          ST_IDLE: begin
            if (!data_s) begin
              state_r   <= ST_DATA;
              bit_cnt_r <= 3'd0;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_DATA: begin
            shift_r <= {data_s, shift_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
          ST_PARITY: begin
            parity_r <= data_s;
            state_r  <= ST_STOP;
          end
          ST_STOP: begin
            if (data_s && odd_parity_ok(shift_r, parity_r)) begin
              byte_valid_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
            end
            state_r <= ST_IDLE;
          end
          default: state_r <= ST_IDLE;
        endcase
      end else if (state_r != ST_IDLE) begin
        if (to_cnt_r == TO_LAST) begin
          frame_err_r <= 1'b1;
          state_r     <= ST_IDLE;
          to_cnt_r    <= '0;
        end else begin
          to_cnt_r <= to_cnt_r + TO_W'(1);
        end
      end else begin
        to_cnt_r <= '0;
      end
    end
  end

  ps2_to_hid u_ps2_to_hid (
    .code ({ext_r, shift_r}),
    .hid  (hid_s)
  );

  // Sequence decoder: tracks E0/F0 prefixes and updates the held keycode
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      keycode_r   <= KEY_NONE;
      key_event_r <= 1'b0;
      ext_r       <= 1'b0;
      brk_r       <= 1'b0;
    end else begin
      key_event_r <= 1'b0;
      if (frame_err_r) begin
        ext_r <= 1'b0;
        brk_r <= 1'b0;
      end else if (byte_valid_r) begin
        if (shift_r == PS2_EXT) begin
          ext_r <= 1'b1;
        end else if (shift_r == PS2_BRK) begin
          brk_r <= 1'b1;
        end else begin
          ext_r <= 1'b0;
          brk_r <= 1'b0;
          // Releasing a key other than the held one leaves the bus alone
          if (hid_s != KEY_NONE) begin
            if (brk_r) begin
              if (hid_s == keycode_r) begin
                keycode_r   <= KEY_NONE;
                key_event_r <= 1'b1;
              end else begin
                keycode_r <= keycode_r;
              end
            end else if (hid_s != keycode_r) begin
              keycode_r   <= hid_s;
              key_event_r <= 1'b1;
            end else begin
              keycode_r <= keycode_r;
            end
          end else begin
            keycode_r <= keycode_r;
          end
        end
      end else begin
        keycode_r <= keycode_r;
      end
    end
  end

  assign bus.keycode   = keycode_r;
  assign bus.key_event = key_event_r;
  assign bus.frame_err = frame_err_r;

endmodule
